// File: rtl/ram_bus_master.sv
// Burst master for a single-port RAM with a shared tri-state data bus.
// Host commands are read/write bursts of up to 16 beats, or a whole-RAM clear.
module ram_bus_master #(
    parameter int Addr_Width = 12,
    parameter int Data_Width = 32
) (
    input  logic                  CLK,
    input  logic                  Rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_cmd,
    input  logic [Addr_Width-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [Data_Width-1:0] wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [Data_Width-1:0] rsp_rdata,
    output logic                  busy,
    inout  wire  [Data_Width-1:0] Mem_Data,
    output logic [Addr_Width-1:0] Mem_Addr,
    output logic                  Mem_R_W,
    output logic                  Mem_CS,
    output logic                  Mem_Rst
);

    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_BEAT, RD_ISSUE, RD_CAP, RD_RESP, CLR, TURN
    } state_t;

    state_t                state_reg, state_next;
    logic [Addr_Width-1:0] addr_reg, addr_next;
    logic [Addr_Width-1:0] mem_addr_reg, mem_addr_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [Data_Width-1:0] wdata_reg, wdata_next;
    logic [Data_Width-1:0] rdata_reg, rdata_next;
    logic                  drive_en;

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            mem_addr_reg <= '0;
            cnt_reg      <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            mem_addr_reg <= mem_addr_next;
            cnt_reg      <= cnt_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Mem_Addr is only reloaded when entering a chip-select state, so it holds while idle.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        mem_addr_next = mem_addr_reg;
        cnt_next      = cnt_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        wdata_ready   = 1'b0;
        rsp_valid     = 1'b0;
        Mem_CS        = 1'b0;
        Mem_R_W       = 1'b1;
        Mem_Rst       = 1'b0;
        drive_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next = req_addr;
                    cnt_next  = req_len;
                    case (req_cmd)
                        2'b00: begin
                            state_next    = RD_ISSUE;
                            mem_addr_next = req_addr;
                        end
                        2'b01:   state_next = WR_WAIT;
                        2'b10:   state_next = CLR;
                        default: state_next = IDLE;
                    endcase
                end
            end
            WR_WAIT: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    wdata_next    = wdata;
                    mem_addr_next = addr_reg;
                    state_next    = WR_BEAT;
                end
            end
            WR_BEAT: begin
                Mem_CS   = 1'b1;
                Mem_R_W  = 1'b0;
                drive_en = 1'b1;
                if (cnt_reg == 4'd0) begin
                    state_next = TURN;
                end else begin
                    cnt_next   = cnt_reg - 4'd1;
                    addr_next  = addr_reg + 1'b1;
                    state_next = WR_WAIT;
                end
            end
            RD_ISSUE: begin
                Mem_CS     = 1'b1;
                state_next = RD_CAP;
            end
            RD_CAP: begin
                Mem_CS     = 1'b1;
                rdata_next = Mem_Data;
                state_next = RD_RESP;
            end
            RD_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (cnt_reg == 4'd0) begin
                        state_next = TURN;
                    end else begin
                        cnt_next      = cnt_reg - 4'd1;
                        addr_next     = addr_reg + 1'b1;
                        mem_addr_next = addr_reg + 1'b1;
                        state_next    = RD_ISSUE;
                    end
                end
            end
            CLR: begin
                Mem_Rst    = 1'b1;
                state_next = TURN;
            end
            TURN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by Rst so the host sees no ready while the master is held in reset.
    assign req_ready = Rst && (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign rsp_rdata = rdata_reg;
    assign Mem_Addr  = mem_addr_reg;

    generate
        for (genvar gi = 0; gi < Data_Width; gi++) begin : g_bus
            assign Mem_Data[gi] = drive_en ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master: table of bursts against a behavioural RAM,
// plus hand-written reset-abort and held-request sequences.
module tb_ram_bus_master;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          Rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_cmd;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    wire  [DW-1:0] Mem_Data;
    logic [AW-1:0] Mem_Addr;
    logic          Mem_R_W, Mem_CS, Mem_Rst;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_bus_master #(.Addr_Width(AW), .Data_Width(DW)) dut (
        .CLK(CLK), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .Mem_Data(Mem_Data), .Mem_Addr(Mem_Addr),
        .Mem_R_W(Mem_R_W), .Mem_CS(Mem_CS), .Mem_Rst(Mem_Rst)
    );

    // Behavioural RAM: combinational read while selected for read, write and clear on the edge
    logic [DW-1:0] ram [0:(1<<AW)-1];
    assign Mem_Data = (Mem_CS && Mem_R_W) ? ram[Mem_Addr] : 'z;

    always @(posedge CLK) begin
        if (Mem_Rst) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
        end else if (Mem_CS && !Mem_R_W) begin
            ram[Mem_Addr] <= Mem_Data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: whenever the RAM is selected for read, the bus must carry the RAM's value
    always @(negedge CLK) begin
        if (Rst && Mem_CS && Mem_R_W)
            chk("bus_rd", Mem_Data, ram[Mem_Addr]);
    end

    typedef struct {
        logic [1:0]  kind;      // 0 read, 1 write, 2 clear, 3 reserved
        logic [11:0] addr;
        logic [3:0]  len;
        logic [31:0] d [4];     // write data, or expected read data
        int          stall;
        bit          hold;      // keep req_valid asserted for the whole burst
    } tv_t;

    tv_t tv [11];

    task automatic accept(input logic [1:0] cmd, input logic [11:0] a, input logic [3:0] l,
                          input bit hold);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_cmd = cmd; req_addr = a; req_len = l;
        @(negedge CLK);
        if (!hold) req_valid = 1'b0;
        else       req_cmd   = 2'b10;
    endtask

    task automatic idle_after_turn(input bit hold);
        chk("turn_busy", 32'(busy), 32'd1);
        chk("turn_cs", 32'(Mem_CS), 32'd0);
        chk("turn_rw", 32'(Mem_R_W), 32'd1);
        chk("turn_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        if (hold) req_valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic run_write(input int v);
        logic [11:0] a;
        a = tv[v].addr;
        accept(2'b01, a, tv[v].len, tv[v].hold);
        for (int i = 0; i <= int'(tv[v].len); i++) begin
            chk("wdata_ready", 32'(wdata_ready), 32'd1);
            chk("wait_cs", 32'(Mem_CS), 32'd0);
            if (tv[v].hold) chk("req_ready_busy", 32'(req_ready), 32'd0);
            wdata_valid = 1'b1; wdata = tv[v].d[i];
            @(negedge CLK);
            wdata_valid = 1'b0;
            chk("wr_cs", 32'(Mem_CS), 32'd1);
            chk("wr_rw", 32'(Mem_R_W), 32'd0);
            chk("wr_addr", 32'(Mem_Addr), 32'(a));
            chk("wr_data", Mem_Data, tv[v].d[i]);
            if (tv[v].hold) chk("req_ready_busy", 32'(req_ready), 32'd0);
            a = a + 12'd1;
            @(negedge CLK);
        end
        idle_after_turn(tv[v].hold);
    endtask

    task automatic run_read(input int v);
        logic [11:0] a;
        a = tv[v].addr;
        accept(2'b00, a, tv[v].len, 1'b0);
        for (int i = 0; i <= int'(tv[v].len); i++) begin
            chk("iss_cs", 32'(Mem_CS), 32'd1);
            chk("iss_rw", 32'(Mem_R_W), 32'd1);
            chk("iss_addr", 32'(Mem_Addr), 32'(a));
            chk("iss_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge CLK);
            chk("cap_cs", 32'(Mem_CS), 32'd1);
            chk("cap_addr", 32'(Mem_Addr), 32'(a));
            chk("cap_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge CLK);
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_cs", 32'(Mem_CS), 32'd0);
            chk("rsp_rdata", rsp_rdata, tv[v].d[i]);
            for (int s = 0; s < tv[v].stall; s++) begin
                @(negedge CLK);
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_rdata", rsp_rdata, tv[v].d[i]);
                chk("stall_cs", 32'(Mem_CS), 32'd0);
                chk("stall_addr", 32'(Mem_Addr), 32'(a));
            end
            rsp_ready = 1'b1;
            @(negedge CLK);
            rsp_ready = 1'b0;
            a = a + 12'd1;
        end
        idle_after_turn(1'b0);
    endtask

    task automatic run_clear();
        accept(2'b10, 12'h000, 4'd0, 1'b0);
        chk("clr_mem_rst", 32'(Mem_Rst), 32'd1);
        chk("clr_cs", 32'(Mem_CS), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        @(negedge CLK);
        chk("clr_mem_rst_once", 32'(Mem_Rst), 32'd0);
        idle_after_turn(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{kind: 2'd1, addr: 12'h005, len: 4'd0, d: '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, stall: 0, hold: 1'b0};
        tv[1]  = '{kind: 2'd0, addr: 12'h005, len: 4'd0, d: '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, stall: 0, hold: 1'b0};
        tv[2]  = '{kind: 2'd1, addr: 12'hFFE, len: 4'd3, d: '{32'd1, 32'd2, 32'd3, 32'd4}, stall: 0, hold: 1'b0};
        tv[3]  = '{kind: 2'd0, addr: 12'hFFE, len: 4'd3, d: '{32'd1, 32'd2, 32'd3, 32'd4}, stall: 0, hold: 1'b0};
        tv[4]  = '{kind: 2'd1, addr: 12'h010, len: 4'd2, d: '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'h0}, stall: 0, hold: 1'b0};
        tv[5]  = '{kind: 2'd0, addr: 12'h010, len: 4'd2, d: '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'h0}, stall: 5, hold: 1'b0};
        tv[6]  = '{kind: 2'd2, addr: 12'h000, len: 4'd0, d: '{32'h0, 32'h0, 32'h0, 32'h0}, stall: 0, hold: 1'b0};
        tv[7]  = '{kind: 2'd0, addr: 12'h005, len: 4'd0, d: '{32'h0, 32'h0, 32'h0, 32'h0}, stall: 0, hold: 1'b0};
        tv[8]  = '{kind: 2'd0, addr: 12'hFFF, len: 4'd1, d: '{32'h0, 32'h0, 32'h0, 32'h0}, stall: 1, hold: 1'b0};
        tv[9]  = '{kind: 2'd1, addr: 12'h020, len: 4'd1, d: '{32'h5A5A0001, 32'h5A5A0002, 32'h0, 32'h0}, stall: 0, hold: 1'b1};
        tv[10] = '{kind: 2'd0, addr: 12'h020, len: 4'd1, d: '{32'h5A5A0001, 32'h5A5A0002, 32'h0, 32'h0}, stall: 0, hold: 1'b0};

        Rst = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(Mem_CS), 32'd0);
        chk("rst_rw", 32'(Mem_R_W), 32'd1);
        chk("rst_mem_rst", 32'(Mem_Rst), 32'd0);
        chk("rst_addr", 32'(Mem_Addr), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        repeat (2) @(negedge CLK);
        Rst = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 11; v++) begin
            $display("vector %0d kind %0d addr 0x%03h len %0d", v, tv[v].kind, tv[v].addr, tv[v].len);
            case (tv[v].kind)
                2'd0: run_read(v);
                2'd1: run_write(v);
                2'd2: run_clear();
                default: ;
            endcase
            @(negedge CLK);
        end

        // Reserved command is accepted and returns straight to idle
        accept(2'b11, 12'h123, 4'd5, 1'b0);
        chk("rsv_busy", 32'(busy), 32'd0);
        chk("rsv_req_ready", 32'(req_ready), 32'd1);
        chk("rsv_cs", 32'(Mem_CS), 32'd0);
        $display("reserved command done");

        // Reset asserted during the second beat of a four-beat write
        @(negedge CLK);
        accept(2'b01, 12'h100, 4'd3, 1'b0);
        wdata_valid = 1'b1; wdata = 32'h11111111;
        @(negedge CLK);
        wdata_valid = 1'b0;
        @(negedge CLK);
        wdata_valid = 1'b1; wdata = 32'h22222222;
        @(negedge CLK);
        wdata_valid = 1'b0;
        chk("abort_beat_cs", 32'(Mem_CS), 32'd1);
        Rst = 1'b0;
        #1;
        chk("abort_cs", 32'(Mem_CS), 32'd0);
        chk("abort_rw", 32'(Mem_R_W), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_addr", 32'(Mem_Addr), 32'd0);
        repeat (2) @(negedge CLK);
        Rst = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
        wdata_valid = 1'b1; wdata = 32'h33333333;
        repeat (2) begin
            @(negedge CLK);
            chk("release_wdata_ready", 32'(wdata_ready), 32'd0);
            chk("release_busy_idle", 32'(busy), 32'd0);
        end
        wdata_valid = 1'b0;
        chk("abort_ram_beat1", ram[12'h100], 32'h11111111);
        chk("abort_ram_beat2", ram[12'h101], 32'h00000000);
        $display("reset abort sequence done");

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
